// File: rtl/mem_copy_master_if.sv
// Memory bus between the copy master and a single-port register-file slave.
// Signal names follow the master's point of view: o* driven by the master,
// i* returned by the slave.
interface mem_copy_master_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 4
);
    logic                     oChipSelect_n;
    logic                     oRead_n;
    logic                     oWrite_n;
    logic [ADDRESS_WIDTH-1:0] oAddress;
    logic [DATA_WIDTH-1:0]    oData;
    logic [DATA_WIDTH-1:0]    iData;

    modport master (
        output oChipSelect_n, oRead_n, oWrite_n, oAddress, oData,
        input  iData
    );

    modport slave (
        input  oChipSelect_n, oRead_n, oWrite_n, oAddress, oData,
        output iData
    );
endinterface

// File: rtl/mem_copy_master.sv
// Block copy / fill initiator for the register-file memory slave.
// Copy moves one word per READ -> WAIT -> WRITE sequence in ascending order;
// fill issues back-to-back WRITE cycles. Every output is a register, so each
// state's bus values are loaded on the edge that enters that state.
module mem_copy_master #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 4
) (
    input  logic                     iClk,
    input  logic                     iReset,
    input  logic                     iStart,
    input  logic                     iMode,
    input  logic [ADDRESS_WIDTH-1:0] iSrcAddress,
    input  logic [ADDRESS_WIDTH-1:0] iDstAddress,
    input  logic [ADDRESS_WIDTH:0]   iLength,
    input  logic [DATA_WIDTH-1:0]    iFillData,
    output logic                     oBusy,
    output logic                     oDone,
    mem_copy_master_if.master        bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic MODE_FILL = 1'b1;

    logic [2:0]               state;
    logic                     mode;
    logic [ADDRESS_WIDTH-1:0] srcPointer;
    logic [ADDRESS_WIDTH-1:0] dstPointer;
    logic [ADDRESS_WIDTH:0]   remaining;
    logic [DATA_WIDTH-1:0]    fillData;
    logic                     lastWord;

    assign lastWord = (remaining == (ADDRESS_WIDTH+1)'(1));

    // FSM, command capture and registered bus outputs; oData doubles as the copy buffer.
    always_ff @(posedge iClk) begin
        // NOTE: reset is synchronous here, so it lives inside the clocked branch with no edge on iReset in the sensitivity list; all state uses <= so every register sees pre-edge values.
        if (iReset) begin
            state             <= IDLE;
            mode              <= 1'b0;
            srcPointer        <= '0;
            dstPointer        <= '0;
            remaining         <= '0;
            fillData          <= '0;
            oBusy             <= 1'b0;
            oDone             <= 1'b0;
            bus.oChipSelect_n <= 1'b1;
            bus.oRead_n       <= 1'b1;
            bus.oWrite_n      <= 1'b1;
            bus.oAddress      <= '0;
            bus.oData         <= '0;
        end else begin
            // NOTE: defaults first; each state overrides only the strobes it drives low, so no cycle can inherit a stale strobe.
            oDone             <= 1'b0;
            bus.oChipSelect_n <= 1'b1;
            bus.oRead_n       <= 1'b1;
            bus.oWrite_n      <= 1'b1;
            case (state)
                IDLE: begin
                    oBusy <= 1'b0;
                    if (iStart) begin
                        mode       <= iMode;
                        srcPointer <= iSrcAddress;
                        dstPointer <= iDstAddress;
                        remaining  <= iLength;
                        fillData   <= iFillData;
                        if (iLength == '0) begin
                            state <= DONE;
                            oDone <= 1'b1;
                        end else if (iMode == MODE_FILL) begin
                            state             <= WRITE;
                            oBusy             <= 1'b1;
                            bus.oChipSelect_n <= 1'b0;
                            bus.oWrite_n      <= 1'b0;
                            bus.oAddress      <= iDstAddress;
                            bus.oData         <= iFillData;
                        end else begin
                            state             <= READ;
                            oBusy             <= 1'b1;
                            bus.oChipSelect_n <= 1'b0;
                            bus.oRead_n       <= 1'b0;
                            bus.oAddress      <= iSrcAddress;
                        end
                    end
                end
                READ: begin
                    // Slave registers the address on this edge; data is valid during WAIT.
                    state <= WAIT;
                end
                WAIT: begin
                    state             <= WRITE;
                    bus.oChipSelect_n <= 1'b0;
                    bus.oWrite_n      <= 1'b0;
                    bus.oAddress      <= dstPointer;
                    bus.oData         <= bus.iData;
                end
                WRITE: begin
                    // Pointers wrap silently at the top of the address space.
                    srcPointer <= srcPointer + 1'b1;
                    dstPointer <= dstPointer + 1'b1;
                    remaining  <= remaining - 1'b1;
                    if (lastWord) begin
                        state <= DONE;
                        oBusy <= 1'b0;
                        oDone <= 1'b1;
                    end else if (mode == MODE_FILL) begin
                        bus.oChipSelect_n <= 1'b0;
                        bus.oWrite_n      <= 1'b0;
                        bus.oAddress      <= dstPointer + 1'b1;
                        bus.oData         <= fillData;
                    end else begin
                        state             <= READ;
                        bus.oChipSelect_n <= 1'b0;
                        bus.oRead_n       <= 1'b0;
                        bus.oAddress      <= srcPointer + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    oBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_master.sv
// Scoreboard bench for mem_copy_master: stimulus pushes expected bus reads,
// writes and oDone cycles; a negedge monitor pops and compares them.
module tb_mem_copy_master;

    localparam int DW = 32;
    localparam int AW = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wrExp_t;

    logic          iClk = 1'b0;
    logic          iReset = 1'b1;
    logic          iStart = 1'b0;
    logic          iMode = 1'b0;
    logic [AW-1:0] iSrcAddress = '0;
    logic [AW-1:0] iDstAddress = '0;
    logic [AW:0]   iLength = '0;
    logic [DW-1:0] iFillData = '0;
    logic          oBusy;
    logic          oDone;

    mem_copy_master_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    mem_copy_master #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .iClk        (iClk),
        .iReset      (iReset),
        .iStart      (iStart),
        .iMode       (iMode),
        .iSrcAddress (iSrcAddress),
        .iDstAddress (iDstAddress),
        .iLength     (iLength),
        .iFillData   (iFillData),
        .oBusy       (oBusy),
        .oDone       (oDone),
        .bus         (bus)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    logic [AW-1:0] expRdQ[$];
    wrExp_t        expWrQ[$];
    int            expDoneQ[$];

    // Slave model: registered read address, combinational read data.
    logic [DW-1:0] mem [16];
    logic [AW-1:0] rdAddr = '0;
    logic          plEn = 1'b0;
    logic [AW-1:0] plAddr = '0;
    logic [DW-1:0] plData = '0;

    always @(posedge iClk) begin
        cyc <= cyc + 1;
        if (plEn)
            mem[plAddr] <= plData;
        else if (bus.oChipSelect_n === 1'b0 && bus.oWrite_n === 1'b0)
            mem[bus.oAddress] <= bus.oData;
        if (bus.oChipSelect_n === 1'b0 && bus.oRead_n === 1'b0)
            rdAddr <= bus.oAddress;
    end
    assign bus.iData = mem[rdAddr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: compare every bus cycle and oDone pulse against the scoreboard.
    always @(negedge iClk) begin
        if (bus.oRead_n === 1'b0 || bus.oWrite_n === 1'b0) begin
            check("strobe_exclusive", 64'(bus.oRead_n | bus.oWrite_n), 64'd1);
            check("cs_with_strobe", 64'(bus.oChipSelect_n), 64'd0);
            check("busy_on_bus", 64'(oBusy), 64'd1);
        end
        if (bus.oChipSelect_n === 1'b0 && bus.oRead_n === 1'b0) begin
            check("read_pending", 64'(expRdQ.size() > 0), 64'd1);
            if (expRdQ.size() > 0) check("read_addr", 64'(bus.oAddress), 64'(expRdQ.pop_front()));
        end
        if (bus.oChipSelect_n === 1'b0 && bus.oWrite_n === 1'b0) begin
            check("write_pending", 64'(expWrQ.size() > 0), 64'd1);
            if (expWrQ.size() > 0) begin
                wrExp_t e;
                e = expWrQ.pop_front();
                check("write_addr", 64'(bus.oAddress), 64'(e.addr));
                check("write_data", 64'(bus.oData), 64'(e.data));
            end
        end
        if (oDone === 1'b1) begin
            check("done_pending", 64'(expDoneQ.size() > 0), 64'd1);
            check("done_busy_low", 64'(oBusy), 64'd0);
            if (expDoneQ.size() > 0) check("done_cycle", 64'(cyc), 64'(expDoneQ.pop_front()));
        end
    end

    task automatic step();
        @(negedge iClk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        plEn = 1'b1;
        plAddr = a;
        plData = d;
        step();
        plEn = 1'b0;
    endtask

    // latency = cycles from the start edge to oDone; 0 means no oDone expected.
    task automatic startCmd(input logic mode, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                            input logic [AW:0] len, input logic [DW-1:0] fill, input int latency);
        iStart = 1'b1;
        iMode = mode;
        iSrcAddress = src;
        iDstAddress = dst;
        iLength = len;
        iFillData = fill;
        if (latency > 0) expDoneQ.push_back(cyc + latency);
        step();
        iStart = 1'b0;
        iMode = ~mode;
        iSrcAddress = ~src;
        iDstAddress = ~dst;
        iLength = '0;
        iFillData = ~fill;
    endtask

    task automatic waitDone(input int bound);
        for (int i = 0; i < bound && expDoneQ.size() != 0; i++) step();
        check("done_timeout", 64'(expDoneQ.size()), 64'd0);
        repeat (3) step();
        check("reads_consumed", 64'(expRdQ.size()), 64'd0);
        check("writes_consumed", 64'(expWrQ.size()), 64'd0);
    endtask

    task automatic pushWr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wrExp_t e;
        e.addr = a;
        e.data = d;
        expWrQ.push_back(e);
    endtask

    initial begin
        // Reset values.
        step();
        check("rst_cs", 64'(bus.oChipSelect_n), 64'd1);
        check("rst_rd", 64'(bus.oRead_n), 64'd1);
        check("rst_wr", 64'(bus.oWrite_n), 64'd1);
        check("rst_addr", 64'(bus.oAddress), 64'd0);
        check("rst_data", 64'(bus.oData), 64'd0);
        check("rst_busy", 64'(oBusy), 64'd0);
        check("rst_done", 64'(oDone), 64'd0);
        step();
        iReset = 1'b0;
        for (int i = 0; i < 16; i++) preload(AW'(i), 32'h0);

        // Copy src 0 -> dst 8, 4 words; oDone at cycle 13.
        for (int i = 0; i < 4; i++) preload(AW'(i), 32'hA0 + i);
        for (int i = 0; i < 4; i++) begin
            expRdQ.push_back(AW'(i));
            pushWr(AW'(8 + i), 32'hA0 + i);
        end
        startCmd(1'b0, 4'd0, 4'd8, 5'd4, 32'h0, 13);
        check("copy_busy", 64'(oBusy), 64'd1);
        waitDone(60);
        for (int i = 0; i < 4; i++) check("copy_mem", 64'(mem[8 + i]), 64'(32'hA0 + i));

        // Fill dst 14, 4 words with wrap; oDone at cycle 5.
        pushWr(4'd14, 32'hDEADBEEF);
        pushWr(4'd15, 32'hDEADBEEF);
        pushWr(4'd0, 32'hDEADBEEF);
        pushWr(4'd1, 32'hDEADBEEF);
        startCmd(1'b1, 4'd0, 4'd14, 5'd4, 32'hDEADBEEF, 5);
        waitDone(60);
        check("fill_mem14", 64'(mem[14]), 64'hDEADBEEF);
        check("fill_mem15", 64'(mem[15]), 64'hDEADBEEF);
        check("fill_mem0", 64'(mem[0]), 64'hDEADBEEF);
        check("fill_mem1", 64'(mem[1]), 64'hDEADBEEF);
        check("fill_mem2_kept", 64'(mem[2]), 64'hA2);

        // Zero length: oDone at cycle 1, no bus activity.
        startCmd(1'b0, 4'd2, 4'd5, 5'd0, 32'h0, 1);
        waitDone(20);
        check("zero_mem5_kept", 64'(mem[5]), 64'h0);

        // Overlapping copy with an ignored second start at cycle 4.
        preload(4'd0, 32'h55);
        preload(4'd1, 32'h11);
        preload(4'd2, 32'h22);
        preload(4'd3, 32'h33);
        for (int i = 0; i < 3; i++) begin
            expRdQ.push_back(AW'(i));
            pushWr(AW'(1 + i), 32'h55);
        end
        startCmd(1'b0, 4'd0, 4'd1, 5'd3, 32'h0, 10);
        repeat (3) step();
        iStart = 1'b1;
        iMode = 1'b1;
        iDstAddress = 4'd7;
        iLength = 5'd5;
        iFillData = 32'hBAD0BAD0;
        step();
        iStart = 1'b0;
        waitDone(60);
        for (int i = 1; i < 4; i++) check("overlap_mem", 64'(mem[i]), 64'h55);
        check("overlap_mem7_kept", 64'(mem[7]), 64'h0);

        // Full range copy onto itself: 48 bus-cycle pattern, contents unchanged.
        for (int i = 0; i < 16; i++) preload(AW'(i), 32'h1000 + i);
        for (int i = 0; i < 16; i++) begin
            expRdQ.push_back(AW'(3 + i));
            pushWr(AW'(3 + i), 32'h1000 + ((3 + i) % 16));
        end
        startCmd(1'b0, 4'd3, 4'd3, 5'd16, 32'h0, 49);
        waitDone(120);
        for (int i = 0; i < 16; i++) check("full_mem", 64'(mem[i]), 64'(32'h1000 + i));

        // Reset held 2 cycles during WRITE of word 1 of a copy.
        for (int i = 0; i < 4; i++) preload(AW'(i), 32'hB0 + i);
        for (int i = 8; i < 12; i++) preload(AW'(i), 32'h0);
        expRdQ.push_back(4'd0);
        expRdQ.push_back(4'd1);
        pushWr(4'd8, 32'hB0);
        pushWr(4'd9, 32'hB1);
        startCmd(1'b0, 4'd0, 4'd8, 5'd4, 32'h0, 0);
        repeat (5) step();
        iReset = 1'b1;
        step();
        check("mid_rst_strobes", 64'({bus.oChipSelect_n, bus.oRead_n, bus.oWrite_n}), 64'b111);
        check("mid_rst_busy", 64'(oBusy), 64'd0);
        check("mid_rst_done", 64'(oDone), 64'd0);
        step();
        iReset = 1'b0;
        repeat (6) step();
        check("mid_rst_idle", 64'(bus.oChipSelect_n), 64'd1);
        check("mid_rst_reads", 64'(expRdQ.size()), 64'd0);
        check("mid_rst_writes", 64'(expWrQ.size()), 64'd0);
        check("mid_rst_mem8", 64'(mem[8]), 64'hB0);
        check("mid_rst_mem9", 64'(mem[9]), 64'hB1);
        check("mid_rst_mem10", 64'(mem[10]), 64'h0);
        check("mid_rst_mem11", 64'(mem[11]), 64'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
